// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control FSM.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWrite,
    StMemWb,
    StExecR,
    StExecI,
    StAluWb,
    StBranch,
    StJal,
    StJalr,
    StJalrPc,
    StLui,
    StTrap
  } state_e;

  // Opcodes
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  // ALU operand A select
  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARd1   = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SrcBRd2  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  // Immediate format select
  localparam logic [2:0] ImmI = 3'b000;
  localparam logic [2:0] ImmS = 3'b001;
  localparam logic [2:0] ImmB = 3'b010;
  localparam logic [2:0] ImmJ = 3'b011;
  localparam logic [2:0] ImmU = 3'b100;

  // ALU operation class
  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;

  // Result mux select
  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResData      = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;
  localparam logic [1:0] ResImm       = 2'b11;

  // Trap causes
  localparam logic [1:0] CauseNone    = 2'b00;
  localparam logic [1:0] CauseIllegal = 2'b01;
  localparam logic [1:0] CauseTimeout = 2'b10;

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluation from funct3 and the ALU compare flags.
module branch_cond
  import riscv_ctrl_pkg::*;
#(
  parameter bit UNSIGNED_BR = 1'b1
) (
  input  logic [2:0] funct3_i,
  input  logic       zero_i,
  input  logic       alu_r31_i,
  output logic       take_o,
  output logic       alu_unsigned_o,
  output logic       illegal_o
);

  // Decode funct3 into taken flag, compare signedness and legality.
  always_comb begin
    take_o         = 1'b0;
    alu_unsigned_o = 1'b0;
    illegal_o      = 1'b0;
    case (funct3_i)
      3'b000: take_o = zero_i;
      3'b001: take_o = !zero_i;
      3'b100: take_o = alu_r31_i;
      3'b101: take_o = !alu_r31_i;
      3'b110: begin
        if (UNSIGNED_BR) begin
          take_o         = alu_r31_i;
          alu_unsigned_o = 1'b1;
        end else begin
          illegal_o = 1'b1;
        end
      end
      3'b111: begin
        if (UNSIGNED_BR) begin
          take_o         = !alu_r31_i;
          alu_unsigned_o = 1'b1;
        end else begin
          illegal_o = 1'b1;
        end
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for a multicycle RV32I core sharing one memory port for fetch and data.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32,
  parameter bit          UNSIGNED_BR = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             Zero,
  input  logic             ALUR31,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             MemWrite,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ImmSrc,
  output logic [1:0]       ALUOp,
  output logic             ALUUnsigned,
  output logic [1:0]       ResultSrc,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [WaitW-1:0]   wait_q, wait_d;
  logic [1:0]         cause_q, cause_d;
  logic [CNT_W-1:0]   instret_q, instret_d;
  logic               retire;
  logic               wait_expired;
  logic               br_take, br_unsigned, br_illegal;

  branch_cond #(
    .UNSIGNED_BR(UNSIGNED_BR)
  ) u_branch_cond (
    .funct3_i      (funct3),
    .zero_i        (Zero),
    .alu_r31_i     (ALUR31),
    .take_o        (br_take),
    .alu_unsigned_o(br_unsigned),
    .illegal_o     (br_illegal)
  );

  // Counter has already seen MEM_TIMEOUT idle cycles; one more idle cycle traps.
  assign wait_expired = (wait_q == WaitW'(MEM_TIMEOUT));

  // Next-state, wait counter, trap cause and datapath control decode.
  always_comb begin
    state_d     = state_q;
    wait_d      = '0;
    cause_d     = cause_q;
    retire      = 1'b0;
    mem_req     = 1'b0;
    MemWrite    = 1'b0;
    AdrSrc      = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = SrcAPc;
    ALUSrcB     = SrcBRd2;
    ImmSrc      = ImmI;
    ALUOp       = AluAdd;
    ALUUnsigned = 1'b0;
    ResultSrc   = ResAluOut;
    trap        = 1'b0;

    // While reset is asserted every output stays at its idle value.
    if (reset_n) begin
      case (state_q)
        StFetch: begin
          mem_req   = 1'b1;
          ALUSrcB   = SrcBFour;
          ResultSrc = ResAluResult;
          if (mem_ready) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            state_d = StDecode;
          end else if (wait_expired) begin
            state_d = StTrap;
            cause_d = CauseTimeout;
          end else begin
            wait_d = wait_q + WaitW'(1);
          end
        end
        StDecode: begin
          ALUSrcA = SrcAOldPc;
          ALUSrcB = SrcBImm;
          case (op)
            OpLoad, OpStore: state_d = StMemAdr;
            OpRType:         state_d = StExecR;
            OpIType:         state_d = StExecI;
            OpBranch: begin
              ImmSrc  = ImmB;
              state_d = StBranch;
            end
            OpJal: begin
              ImmSrc  = ImmJ;
              state_d = StJal;
            end
            OpJalr:          state_d = StJalr;
            OpLui:           state_d = StLui;
            OpAuipc: begin
              ImmSrc  = ImmU;
              state_d = StAluWb;
            end
            default: begin
              state_d = StTrap;
              cause_d = CauseIllegal;
            end
          endcase
        end
        StMemAdr: begin
          ALUSrcA = SrcARd1;
          ALUSrcB = SrcBImm;
          if (op == OpStore) begin
            ImmSrc  = ImmS;
            state_d = StMemWrite;
          end else begin
            state_d = StMemRead;
          end
        end
        StMemRead: begin
          mem_req = 1'b1;
          AdrSrc  = 1'b1;
          if (mem_ready) begin
            state_d = StMemWb;
          end else if (wait_expired) begin
            state_d = StTrap;
            cause_d = CauseTimeout;
          end else begin
            wait_d = wait_q + WaitW'(1);
          end
        end
        StMemWrite: begin
          mem_req  = 1'b1;
          MemWrite = 1'b1;
          AdrSrc   = 1'b1;
          if (mem_ready) begin
            retire  = 1'b1;
            state_d = StFetch;
          end else if (wait_expired) begin
            state_d = StTrap;
            cause_d = CauseTimeout;
          end else begin
            wait_d = wait_q + WaitW'(1);
          end
        end
        StMemWb: begin
          ResultSrc = ResData;
          RegWrite  = 1'b1;
          retire    = 1'b1;
          state_d   = StFetch;
        end
        StExecR: begin
          ALUSrcA = SrcARd1;
          ALUOp   = AluFunct;
          state_d = StAluWb;
        end
        StExecI: begin
          ALUSrcA = SrcARd1;
          ALUSrcB = SrcBImm;
          ALUOp   = AluFunct;
          state_d = StAluWb;
        end
        StAluWb: begin
          RegWrite = 1'b1;
          retire   = 1'b1;
          state_d  = StFetch;
        end
        StBranch: begin
          ALUSrcA     = SrcARd1;
          ALUOp       = AluSub;
          ALUUnsigned = br_unsigned;
          if (br_illegal) begin
            state_d = StTrap;
            cause_d = CauseIllegal;
          end else begin
            PCWrite = br_take;
            retire  = 1'b1;
            state_d = StFetch;
          end
        end
        StJal: begin
          ALUSrcA = SrcAOldPc;
          ALUSrcB = SrcBFour;
          PCWrite = 1'b1;
          state_d = StAluWb;
        end
        StJalr: begin
          ALUSrcA = SrcARd1;
          ALUSrcB = SrcBImm;
          state_d = StJalrPc;
        end
        StJalrPc: begin
          ALUSrcA = SrcAOldPc;
          ALUSrcB = SrcBFour;
          PCWrite = 1'b1;
          state_d = StAluWb;
        end
        StLui: begin
          ImmSrc    = ImmU;
          ResultSrc = ResImm;
          RegWrite  = 1'b1;
          retire    = 1'b1;
          state_d   = StFetch;
        end
        StTrap: begin
          trap = 1'b1;
        end
        default: begin
          state_d = StTrap;
          cause_d = CauseIllegal;
        end
      endcase
    end
  end

  assign instret_d  = instret_q + CNT_W'(retire);
  assign trap_cause = cause_q;
  assign instret    = instret_q;

  // State, wait counter, sticky cause and retire counter with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StFetch;
      wait_q    <= '0;
      cause_q   <= CauseNone;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      cause_q   <= cause_d;
      instret_q <= instret_d;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller.
module tb_multicycle_controller;

  logic        clk;
  logic        reset_n;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        Zero;
  logic        ALUR31;
  logic        mem_ready;
  logic        mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
  logic [1:0]  ALUSrcA, ALUSrcB, ALUOp, ResultSrc, trap_cause;
  logic [2:0]  ImmSrc;
  logic        ALUUnsigned, trap;
  logic [31:0] instret;

  int tests  = 0;
  int failed = 0;

  logic [20:0] outs;
  logic [20:0] want;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_AUI  = 7'b0010111;

  multicycle_controller #(
    .MEM_TIMEOUT(16),
    .CNT_W      (32),
    .UNSIGNED_BR(1'b1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .op         (op),
    .funct3     (funct3),
    .Zero       (Zero),
    .ALUR31     (ALUR31),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .MemWrite   (MemWrite),
    .AdrSrc     (AdrSrc),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .RegWrite   (RegWrite),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .ALUOp      (ALUOp),
    .ALUUnsigned(ALUUnsigned),
    .ResultSrc  (ResultSrc),
    .trap       (trap),
    .trap_cause (trap_cause),
    .instret    (instret)
  );

  assign outs = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ALUSrcA, ALUSrcB,
                 ImmSrc, ALUOp, ALUUnsigned, ResultSrc, trap, trap_cause};

  // Packs an expected control word in the same field order as outs.
  function automatic logic [20:0] ov(input logic rq, input logic mw, input logic ad,
                                     input logic ir, input logic pc, input logic rw,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [2:0] im, input logic [1:0] ao,
                                     input logic un, input logic [1:0] rs,
                                     input logic tp, input logic [1:0] tc);
    return {rq, mw, ad, ir, pc, rw, sa, sb, im, ao, un, rs, tp, tc};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    mem_ready = 1'b0;
    cyc();
    cyc();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; mem_ready = 1'b1; op = OP_LW; funct3 = 3'b010; Zero = 1'b0; ALUR31 = 1'b0;
    cyc();
    #2;
    want = '0;
    if (outs !== want) begin $display("FAIL reset_outs got=%b want=%b", outs, want); failed++; end
    tests++;
    if (instret !== 32'd0) begin $display("FAIL reset_instret got=%0d want=0", instret); failed++; end
    tests++;
    cyc();
  endtask

  task automatic test_lw();
    do_reset();
    op = OP_LW; funct3 = 3'b010; mem_ready = 1'b1;
    #2; want = ov(1,0,0,1,1,0,2'b00,2'b10,3'b000,2'b00,0,2'b10,0,2'b00);
    if (outs !== want) begin $display("FAIL lw_fetch got=%b want=%b", outs, want); failed++; end
    tests++;
    cyc(); #2; want = ov(0,0,0,0,0,0,2'b01,2'b01,3'b000,2'b00,0,2'b00,0,2'b00);
    if (outs !== want) begin $display("FAIL lw_decode got=%b want=%b", outs, want); failed++; end
    tests++;
    cyc(); #2; want = ov(0,0,0,0,0,0,2'b10,2'b01,3'b000,2'b00,0,2'b00,0,2'b00);
    if (outs !== want) begin $display("FAIL lw_memadr got=%b want=%b", outs, want); failed++; end
    tests++;
    cyc(); #2; want = ov(1,0,1,0,0,0,2'b00,2'b00,3'b000,2'b00,0,2'b00,0,2'b00);
    if (outs !== want) begin $display("FAIL lw_memread got=%b want=%b", outs, want); failed++; end
    tests++;
    cyc(); #2; want = ov(0,0,0,0,0,1,2'b00,2'b00,3'b000,2'b00,0,2'b01,0,2'b00);
    if (outs !== want) begin $display("FAIL lw_memwb got=%b want=%b", outs, want); failed++; end
    tests++;
    cyc(); #2; want = ov(1,0,0,1,1,0,2'b00,2'b10,3'b000,2'b00,0,2'b10,0,2'b00);
    if (outs !== want) begin $display("FAIL lw_refetch got=%b want=%b", outs, want); failed++; end
    tests++;
    if (instret !== 32'd1) begin $display("FAIL lw_instret got=%0d want=1", instret); failed++; end
    tests++;
  endtask

  task automatic test_branch();
    do_reset();
    op = OP_BR; funct3 = 3'b000; Zero = 1'b1; ALUR31 = 1'b0; mem_ready = 1'b1;
    cyc(); #2; want = ov(0,0,0,0,0,0,2'b01,2'b01,3'b010,2'b00,0,2'b00,0,2'b00);
    if (outs !== want) begin $display("FAIL beq_decode got=%b want=%b", outs, want); failed++; end
    tests++;
    cyc(); #2; want = ov(0,0,0,0,1,0,2'b10,2'b00,3'b000,2'b01,0,2'b00,0,2'b00);
    if (outs !== want) begin $display("FAIL beq_taken got=%b want=%b", outs, want); failed++; end
    tests++;
    cyc(); funct3 = 3'b110; Zero = 1'b0; ALUR31 = 1'b0;
    cyc(); cyc(); #2; want = ov(0,0,0,0,0,0,2'b10,2'b00,3'b000,2'b01,1,2'b00,0,2'b00);
    if (outs !== want) begin $display("FAIL bltu_not_taken got=%b want=%b", outs, want); failed++; end
    tests++;
    cyc(); #2;
    if (instret !== 32'd2) begin $display("FAIL branch_instret got=%0d want=2", instret); failed++; end
    tests++;
    funct3 = 3'b011;
    cyc(); cyc(); #2; want = ov(0,0,0,0,0,0,2'b10,2'b00,3'b000,2'b01,0,2'b00,0,2'b00);
    if (outs !== want) begin $display("FAIL br_illegal_f3 got=%b want=%b", outs, want); failed++; end
    tests++;
    cyc(); #2; want = ov(0,0,0,0,0,0,2'b00,2'b00,3'b000,2'b00,0,2'b00,1,2'b01);
    if (outs !== want) begin $display("FAIL br_illegal_trap got=%b want=%b", outs, want); failed++; end
    tests++;
    if (instret !== 32'd2) begin $display("FAIL br_illegal_instret got=%0d want=2", instret); failed++; end
    tests++;
  endtask

  task automatic test_timeout();
    do_reset();
    op = OP_LW; funct3 = 3'b010; mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) cyc();
    #2; want = ov(1,0,0,0,0,0,2'b00,2'b10,3'b000,2'b00,0,2'b10,0,2'b00);
    if (outs !== want) begin $display("FAIL timeout_16_wait got=%b want=%b", outs, want); failed++; end
    tests++;
    cyc(); #2; want = ov(0,0,0,0,0,0,2'b00,2'b00,3'b000,2'b00,0,2'b00,1,2'b10);
    if (outs !== want) begin $display("FAIL timeout_trap got=%b want=%b", outs, want); failed++; end
    tests++;
    mem_ready = 1'b1;
    cyc(); #2;
    if (outs !== want) begin $display("FAIL timeout_sticky got=%b want=%b", outs, want); failed++; end
    tests++;
    do_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) cyc();
    mem_ready = 1'b1;
    #2; want = ov(1,0,0,1,1,0,2'b00,2'b10,3'b000,2'b00,0,2'b10,0,2'b00);
    if (outs !== want) begin $display("FAIL ready_cycle16 got=%b want=%b", outs, want); failed++; end
    tests++;
    cyc(); #2; want = ov(0,0,0,0,0,0,2'b01,2'b01,3'b000,2'b00,0,2'b00,0,2'b00);
    if (outs !== want) begin $display("FAIL ready16_decode got=%b want=%b", outs, want); failed++; end
    tests++;
  endtask

  task automatic test_illegal();
    do_reset();
    op = OP_LW; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    op = 7'b0000000;
    cyc(); #2; want = ov(0,0,0,0,0,0,2'b01,2'b01,3'b000,2'b00,0,2'b00,0,2'b00);
    if (outs !== want) begin $display("FAIL illegal_decode got=%b want=%b", outs, want); failed++; end
    tests++;
    cyc(); cyc(); #2; want = ov(0,0,0,0,0,0,2'b00,2'b00,3'b000,2'b00,0,2'b00,1,2'b01);
    if (outs !== want) begin $display("FAIL illegal_trap got=%b want=%b", outs, want); failed++; end
    tests++;
    if (instret !== 32'd1) begin $display("FAIL illegal_instret got=%0d want=1", instret); failed++; end
    tests++;
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1; mem_ready = 1'b0;
    #2; want = ov(1,0,0,0,0,0,2'b00,2'b10,3'b000,2'b00,0,2'b10,0,2'b00);
    if (outs !== want) begin $display("FAIL trap_reset_fetch got=%b want=%b", outs, want); failed++; end
    tests++;
    if (instret !== 32'd0) begin $display("FAIL trap_reset_instret got=%0d want=0", instret); failed++; end
    tests++;
  endtask

  task automatic test_jalr();
    do_reset();
    op = OP_JALR; funct3 = 3'b000; mem_ready = 1'b1;
    cyc(); cyc(); #2; want = ov(0,0,0,0,0,0,2'b10,2'b01,3'b000,2'b00,0,2'b00,0,2'b00);
    if (outs !== want) begin $display("FAIL jalr_state got=%b want=%b", outs, want); failed++; end
    tests++;
    cyc(); #2; want = ov(0,0,0,0,1,0,2'b01,2'b10,3'b000,2'b00,0,2'b00,0,2'b00);
    if (outs !== want) begin $display("FAIL jalrpc_state got=%b want=%b", outs, want); failed++; end
    tests++;
    cyc(); #2; want = ov(0,0,0,0,0,1,2'b00,2'b00,3'b000,2'b00,0,2'b00,0,2'b00);
    if (outs !== want) begin $display("FAIL jalr_aluwb got=%b want=%b", outs, want); failed++; end
    tests++;
    cyc(); #2;
    if (instret !== 32'd1) begin $display("FAIL jalr_instret got=%0d want=1", instret); failed++; end
    tests++;
  endtask

  task automatic test_alu_lui();
    do_reset();
    op = OP_LUI; mem_ready = 1'b1;
    cyc(); cyc(); #2; want = ov(0,0,0,0,0,1,2'b00,2'b00,3'b100,2'b00,0,2'b11,0,2'b00);
    if (outs !== want) begin $display("FAIL lui_state got=%b want=%b", outs, want); failed++; end
    tests++;
    cyc(); op = OP_AUI;
    cyc(); #2; want = ov(0,0,0,0,0,0,2'b01,2'b01,3'b100,2'b00,0,2'b00,0,2'b00);
    if (outs !== want) begin $display("FAIL auipc_decode got=%b want=%b", outs, want); failed++; end
    tests++;
    cyc(); cyc(); op = OP_R;
    cyc(); cyc(); #2; want = ov(0,0,0,0,0,0,2'b10,2'b00,3'b000,2'b10,0,2'b00,0,2'b00);
    if (outs !== want) begin $display("FAIL execr_state got=%b want=%b", outs, want); failed++; end
    tests++;
    cyc(); cyc(); #2;
    if (instret !== 32'd3) begin $display("FAIL alu_instret got=%0d want=3", instret); failed++; end
    tests++;
  endtask

  task automatic test_reset_mid_store();
    do_reset();
    op = OP_SW; funct3 = 3'b010; mem_ready = 1'b1;
    cyc(); cyc(); #2; want = ov(0,0,0,0,0,0,2'b10,2'b01,3'b001,2'b00,0,2'b00,0,2'b00);
    if (outs !== want) begin $display("FAIL sw_memadr got=%b want=%b", outs, want); failed++; end
    tests++;
    mem_ready = 1'b0;
    cyc(); #2; want = ov(1,1,1,0,0,0,2'b00,2'b00,3'b000,2'b00,0,2'b00,0,2'b00);
    if (outs !== want) begin $display("FAIL sw_memwrite got=%b want=%b", outs, want); failed++; end
    tests++;
    reset_n = 1'b0;
    #2; want = '0;
    if (outs !== want) begin $display("FAIL sw_reset_outs got=%b want=%b", outs, want); failed++; end
    tests++;
    cyc();
    reset_n = 1'b1;
    #2; want = ov(1,0,0,0,0,0,2'b00,2'b10,3'b000,2'b00,0,2'b10,0,2'b00);
    if (outs !== want) begin $display("FAIL sw_reset_fetch got=%b want=%b", outs, want); failed++; end
    tests++;
    if (instret !== 32'd0) begin $display("FAIL sw_reset_instret got=%0d want=0", instret); failed++; end
    tests++;
  endtask

  initial begin
    reset_n = 1'b0; op = '0; funct3 = '0; Zero = 1'b0; ALUR31 = 1'b0; mem_ready = 1'b0;
    #1;
    test_reset();
    test_lw();
    test_branch();
    test_timeout();
    test_illegal();
    test_jalr();
    test_alu_lui();
    test_reset_mid_store();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM for a multicycle RV32I core with a shared instruction/data memory port behind a req/ready handshake.
- Each instruction is sequenced through fetch, decode, execute, memory and writeback states. The FSM drives all datapath selects and enables.
- Full branch resolution (beq..bgeu), lui/auipc, jal/jalr, a memory-timeout trap, an illegal-instruction trap and a retired-instruction counter.
- Sits beside the existing datapath. Successor to the single-cycle decoder.

Parameters:
- MEM_TIMEOUT, 16, max consecutive wait cycles on mem_ready before trapping; legal range ≥1.
- CNT_W, 32, width of the retired-instruction counter.
- UNSIGNED_BR, 1, 1 = bltu/bgeu supported; 0 = funct3 110/111 on a branch is illegal.

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  synchronous active-low reset: sampled at posedge clk, 0 = reset
- op  in  7  instruction opcode from the instruction register
- funct3  in  3  instruction funct3
- Zero  in  1  ALU result == 0
- ALUR31  in  1  ALU less-than flag: signed when ALUUnsigned=0, unsigned when 1
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request valid
- MemWrite  out  1  request is a store
- AdrSrc  out  1  0 = PC, 1 = Result
- IRWrite  out  1  load IR and OldPC
- PCWrite  out  1  PC <= Result
- RegWrite  out  1  register file write enable
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 RD1
- ALUSrcB  out  2  00 RD2, 01 ImmExt, 10 constant 4
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- ALUOp  out  2  00 add, 01 sub/compare, 10 funct-decoded
- ALUUnsigned  out  1  unsigned compare select
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt
- trap  out  1  sticky error flag
- trap_cause  out  2  00 none, 01 illegal instruction, 10 memory timeout
- instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset (reset_n=0 at a posedge): state <= FETCH; wait counter, instret and trap_cause cleared.
  - Reset wins over any other event and aborts any outstanding request.
  - All outputs are Moore decodes of state, except PCWrite and IRWrite/PCWrite in FETCH. Every enable is 0 in reset and in TRAP.
  - Unused selects are driven 0, never x.
- FETCH:
  - Drives mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - On mem_ready: IRWrite=1 and PCWrite=1 in the same cycle, then go to DECODE. Otherwise stay.
- DECODE:
  - Computes ALUOut = OldPC + ImmExt: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
  - ImmSrc by op: B for branch, J for jal, U for auipc, I otherwise.
  - Next state by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR
    - 0110111 -> LUI
    - 0010111 -> ALUWB
    - anything else -> TRAP with cause 01
- MEMADR: ALUSrcA=10, ALUSrcB=01, ImmSrc I (load) or S (store). Go to MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: mem_req=1, AdrSrc=1, ResultSrc=00. On mem_ready go to MEMWB.
- MEMWRITE: mem_req=1, MemWrite=1, AdrSrc=1, ResultSrc=00. On mem_ready go to FETCH and retire.
- MEMWB: ResultSrc=01, RegWrite=1. Retire, then FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Then ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Retire, then FETCH.
- BRANCH:
  - ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00.
  - Condition by funct3: 000 Zero, 001 !Zero, 100 ALUR31, 101 !ALUR31, 110 ALUR31 with ALUUnsigned=1, 111 !ALUR31 with ALUUnsigned=1.
  - PCWrite = condition. Retire, then FETCH.
  - funct3 010/011, or 110/111 when UNSIGNED_BR=0: no PCWrite, go to TRAP with cause 01.
- JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCWrite=1. Then ALUWB.
- JALR: ALUSrcA=10, ALUSrcB=01, ImmSrc I. Then JALRPC.
- JALRPC: ResultSrc=00, PCWrite=1, ALUSrcA=01, ALUSrcB=10. Then ALUWB.
- LUI: ResultSrc=11, ImmSrc U, RegWrite=1. Retire, then FETCH.
- Memory timeout:
  - The wait counter increments each cycle in FETCH, MEMREAD or MEMWRITE with mem_ready=0, and clears on leaving the state.
  - When the counter reaches MEM_TIMEOUT and mem_ready is still 0, go to TRAP with cause 10.
  - mem_ready on exactly the MEM_TIMEOUT-th cycle completes normally.
- TRAP: absorbing. trap=1, mem_req=0, all enables 0. Left only by reset.
- instret: +1 on each retire event; wraps modulo 2^CNT_W. Exactly one retire per completed instruction.

Decomposition:
- Shared package riscv_ctrl_pkg holds:
  - state enum
  - opcode constants
  - ALUSrcA/ALUSrcB/ImmSrc/ResultSrc/ALUOp encodings
  - trap cause codes
- One sub-module, branch_cond: funct3, Zero, ALUR31 -> take, ALUUnsigned, illegal (combinational).

Test Plan:
- Reset then lw with mem_ready=1 on every request -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. 5 cycles, RegWrite only in MEMWB, instret=1.
- beq with Zero=1, then bltu with ALUR31=0 -> first: PCWrite=1 in BRANCH. Second: ALUUnsigned=1, PCWrite=0. instret=2.
- Fetch with mem_ready held 0 for MEM_TIMEOUT=16 cycles -> TRAP entered on the 17th edge with trap_cause=10. mem_ready on cycle 16 instead -> normal DECODE.
- op=0000000 -> TRAP, cause 01, all enables 0. Then reset_n=0 for one cycle -> FETCH, trap=0, instret=0.
- jalr sequence -> JALR, JALRPC (PCWrite=1), ALUWB (RegWrite=1), 5 cycles total.
- reset_n asserted mid-MEMWRITE -> next cycle FETCH, MemWrite=0, mem_req re-asserted with AdrSrc=0.
